hazard_ctl: RTL

//  Pipeline sequencer for the 5-stage core: detects load-use and multi-cycle EX hazards and

---
 rtl/hazard_ctl_pkg.sv | 28 ++
 rtl/hazard_ctl_if.sv | 39 +++
 rtl/hazard_ctl_match.sv | 20 ++
 rtl/hazard_ctl.sv | 101 ++++++++++
 4 files changed

// File: rtl/hazard_ctl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_ctl_pkg;

    localparam int REGADDRSIZE = 5;
    localparam logic [REGADDRSIZE-1:0] XZR = 5'd31;

    typedef enum logic {
        HZ_RUN     = 1'b0,
        HZ_MULBUSY = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_bubble;
    } hz_ctl_t;

    localparam hz_ctl_t CTL_NORMAL   = hz_ctl_t'(6'b110100);
    localparam hz_ctl_t CTL_LOADUSE  = hz_ctl_t'(6'b000110);
    localparam hz_ctl_t CTL_MULSTALL = hz_ctl_t'(6'b000001);
    localparam hz_ctl_t CTL_FLUSH    = hz_ctl_t'(6'b111111);
    // Reset drains the pipe: ID/EX and EX/MEM keep loading bubbles.
    localparam hz_ctl_t CTL_RESET    = hz_ctl_t'(6'b001111);

endpackage

// File: rtl/hazard_ctl_if.sv
// Observation inputs from ID/EX/MEM and the stage-control outputs of hazard_ctl.
import hazard_ctl_pkg::*;

interface hazard_ctl_if #(
    parameter int CNTSIZE = 32
);
    logic [REGADDRSIZE-1:0] ifid_ra;
    logic [REGADDRSIZE-1:0] ifid_rb;
    logic                   id_usesra;
    logic                   id_usesrb;
    logic                   idex_memread;
    logic                   idex_multi;
    logic                   idex_nop;
    logic [REGADDRSIZE-1:0] idex_rd;
    logic                   branch_taken;
    logic                   pc_write;
    logic                   ifid_write;
    logic                   ifid_flush;
    logic                   idex_write;
    logic                   idex_bubble;
    logic                   exmem_bubble;
    logic                   busy;
    logic [CNTSIZE-1:0]     stall_count;
    logic [CNTSIZE-1:0]     flush_count;

    modport master (
        output ifid_ra, ifid_rb, id_usesra, id_usesrb, idex_memread, idex_multi,
               idex_nop, idex_rd, branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               exmem_bubble, busy, stall_count, flush_count
    );

    modport slave (
        input  ifid_ra, ifid_rb, id_usesra, id_usesrb, idex_memread, idex_multi,
               idex_nop, idex_rd, branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
               exmem_bubble, busy, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctl_match.sv
// Load-use detector: a live load in EX writing a register the ID instruction reads.
import hazard_ctl_pkg::*;

module hazard_ctl_match (
    input  logic [REGADDRSIZE-1:0] ra,
    input  logic [REGADDRSIZE-1:0] rb,
    input  logic                   usesra,
    input  logic                   usesrb,
    input  logic                   memread,
    input  logic                   nop,
    input  logic [REGADDRSIZE-1:0] rd,
    output logic                   loaduse
);
    logic hit_a, hit_b;

    assign hit_a   = usesra && (ra == rd);
    assign hit_b   = usesrb && (rb == rd);
    // XZR reads are constant zero, so a load targeting it never creates a dependency.
    assign loaduse = memread && !nop && (rd != XZR) && (hit_a || hit_b);
endmodule

// File: rtl/hazard_ctl.sv
// Pipeline sequencer: load-use / multi-cycle EX stalls, branch flushes, perf counters.
import hazard_ctl_pkg::*;

module hazard_ctl #(
    parameter int MULCYCLES = 4,
    parameter int CNTSIZE   = 32
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctl_if.slave bus
);
    localparam int CW = (MULCYCLES > 2) ? $clog2(MULCYCLES) : 1;
    localparam logic [CW-1:0] CNT_START = CW'(MULCYCLES - 2);

    hz_state_e          state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    hz_ctl_t            ctl;
    logic               loaduse, mulstart;
    logic [CNTSIZE-1:0] stall_cnt, flush_cnt;

    hazard_ctl_match u_match (
        .ra      (bus.ifid_ra),
        .rb      (bus.ifid_rb),
        .usesra  (bus.id_usesra),
        .usesrb  (bus.id_usesrb),
        .memread (bus.idex_memread),
        .nop     (bus.idex_nop),
        .rd      (bus.idex_rd),
        .loaduse (loaduse)
    );

    assign mulstart = bus.idex_multi && !bus.idex_nop;

    always_comb begin
        ctl     = CTL_NORMAL;
        state_n = state;
        cnt_n   = cnt;
        if (rst) begin
            ctl     = CTL_RESET;
            state_n = HZ_RUN;
            cnt_n   = '0;
        end else if (bus.branch_taken) begin
            // The branch is older than anything in EX, so it also kills a pending mul.
            ctl     = CTL_FLUSH;
            state_n = HZ_RUN;
            cnt_n   = '0;
        end else begin
            case (state)
                HZ_RUN: begin
                    if (mulstart) begin
                        ctl     = CTL_MULSTALL;
                        state_n = HZ_MULBUSY;
                        cnt_n   = CNT_START;
                    end else if (loaduse) begin
                        ctl = CTL_LOADUSE;
                    end
                end
                HZ_MULBUSY: begin
                    if (cnt != '0) begin
                        ctl   = CTL_MULSTALL;
                        cnt_n = cnt - 1'b1;
                    end else begin
                        // Release cycle: the finished mul leaves EX; don't restart on it.
                        ctl     = loaduse ? CTL_LOADUSE : CTL_NORMAL;
                        state_n = HZ_RUN;
                    end
                end
                default: begin
                    state_n = HZ_RUN;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HZ_RUN;
            cnt       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (!ctl.pc_write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (bus.branch_taken && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.pc_write     = ctl.pc_write;
    assign bus.ifid_write   = ctl.ifid_write;
    assign bus.ifid_flush   = ctl.ifid_flush;
    assign bus.idex_write   = ctl.idex_write;
    assign bus.idex_bubble  = ctl.idex_bubble;
    assign bus.exmem_bubble = ctl.exmem_bubble;
    assign bus.busy         = (state == HZ_MULBUSY);
    assign bus.stall_count  = stall_cnt;
    assign bus.flush_count  = flush_cnt;
endmodule
